dm_sort_checker: RTL and testbench
==================================

# dm_sort_checker

Hardware result checker that reads a block of data memory after a program halts and verifies the words are in strictly ascending order. It sits beside `CPU_Pipelined`, watches the fetch PC for a halt address, and then reads data memory through a synchronous read port. It reports busy, done, pass, and the first failing index, replacing hierarchical memory peeking with a synthesizable self-check for the bubble-sort regression.

## Interface
- `BASE_ADDR`, 512: byte address of word 0 of the array.
- `NUM_WORDS`, 12: number of 32-bit words to check; legal range 1..256.
- `HALT_PC`, 92: PC value that triggers the scan.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `pc`  in  32  fetch-stage PC from the CPU.
- `rd_en`  out  1  data-memory read request.
- `rd_addr`  out  32  byte address of the request; always word-aligned.
- `rd_data`  in  32  read data; valid in the cycle after the `rd_en` cycle.
- `busy`  out  1  scan in progress.
- `done`  out  1  scan complete; sticky until `rst`.
- `pass`  out  1  meaningful only when `done`=1. 1 means the array is strictly ascending.
- `fail_index`  out  8  index i of the first word with word[i] <= word[i-1]; 0 if no violation.
- `err_count`  out  8  violation count. Present only with `DM_SORT_CHECKER_ERRCNT_EN`.

## Operation
- FSM states: IDLE, READ, CAPTURE, DONE.
- IDLE:
  - If `pc`==`HALT_PC`, go to READ and set `busy`=1.
  - Otherwise stay in IDLE.
- READ:
  - Drive `rd_en`=1 and `rd_addr`=`BASE_ADDR`+4*idx.
  - Go to CAPTURE.
- CAPTURE: register `rd_data` into `prev`.
  - If idx>0 and `rd_data` <= `prev` (unsigned compare), record a violation.
  - If there is a violation and no error counter, go to DONE.
  - If idx==`NUM_WORDS`-1, go to DONE.
  - Otherwise increment idx and go to READ.
- DONE:
  - `busy`=0, `done`=1.
  - `pass`=1 if and only if no violation was recorded.
  - Stay in DONE until `rst`; `pc` is ignored.
- Triggers:
  - Only IDLE samples `pc`.
  - `pc` held at `HALT_PC` for many cycles gives exactly one scan.
  - A match while busy is ignored.
- `fail_index` latches on the first violation only and is never overwritten.
- `NUM_WORDS`=1: a single read, then `pass`=1.
- Equal adjacent words are a violation.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: every output is 0 (`rd_en`, `rd_addr`, `busy`, `done`, `pass`, `fail_index`, `err_count`). State is IDLE and idx is 0.
- `rst` mid-scan aborts on that edge. No further `rd_en` is issued, and the block waits in IDLE for a new `HALT_PC` match.
- Match sampled at edge T gives:
  - Word i requested in cycle T+1+2i.
  - Word i compared in cycle T+2+2i.
- Full pass: `done` rises at T+2·`NUM_WORDS`+1, which is T+25 for the defaults.
- Early fail at index i (no error counter): `done` rises at T+2i+3.
- `rd_en` is high for exactly one cycle per word and never in consecutive cycles.

## Configuration
- `DM_SORT_CHECKER_ERRCNT_EN` defined:
  - The `err_count` port exists.
  - The scan never stops early; all `NUM_WORDS` words are read.
  - `err_count` counts every violation and saturates at 255.
  - `pass` = (`err_count`==0).
  - `done` always rises at T+2·`NUM_WORDS`+1.
- Not defined:
  - No `err_count` port and no counter logic.
  - The scan stops at the first violation.

## Test plan
- Sorted array 0,11,22,33,44,55,66,77,88,99,110,121 at 512, `pc`=92 at T -> 12 `rd_en` pulses at addresses 512..556; `done`=1 and `pass`=1 at T+25.
- Unsorted array 55,88,0,22,77,11,99,33,110,66,121,44 -> `fail_index`=2, `pass`=0, `done` at T+7, exactly 3 reads.
- Same unsorted array with `DM_SORT_CHECKER_ERRCNT_EN` -> 12 reads, `err_count`=5, `fail_index`=2, `pass`=0, `done` at T+25.
- Duplicate words (word5=word6=55, rest ascending) -> `fail_index`=6, `pass`=0.
- `pc` held at 92 for 100 cycles after `done` -> no further `rd_en`; outputs stable.
- `rst` at T+8 mid-scan -> all outputs 0 next cycle. A later `pc`=92 restarts the scan from address 512 and it completes normally.

Source files
------------

// File: rtl/dm_sort_checker.sv
// Post-halt checker: once the fetch PC reaches HALT_PC, reads NUM_WORDS words from BASE_ADDR and checks they strictly ascend.
// Optional DM_SORT_CHECKER_ERRCNT_EN adds err_count and forces a full scan instead of stopping at the first violation.
module dm_sort_checker #(
  parameter logic [31:0] BASE_ADDR = 32'd512,
  parameter int          NUM_WORDS = 12,
  parameter logic [31:0] HALT_PC   = 32'd92
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_index
`ifdef DM_SORT_CHECKER_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] prev_q;
  logic        viol_q, viol_d;
  logic [7:0]  fail_idx_q, fail_idx_d;
  logic        violation;
  logic        stop;

  // rd_data in CAPTURE is the word requested in the preceding READ cycle
  assign violation = (state_q == CAPTURE) && (idx_q != 8'd0) && (rd_data <= prev_q);

`ifdef DM_SORT_CHECKER_ERRCNT_EN
  assign stop = (idx_q == LAST_IDX);
`else
  assign stop = violation || (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    viol_d     = viol_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      IDLE: begin
        idx_d = 8'd0;
        if (pc == HALT_PC) state_d = READ;
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        if (violation) begin
          viol_d = 1'b1;
          if (!viol_q) fail_idx_d = idx_q;
        end
        if (stop) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      prev_q     <= 32'd0;
      viol_q     <= 1'b0;
      fail_idx_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      viol_q     <= viol_d;
      fail_idx_q <= fail_idx_d;
      if (state_q == CAPTURE) prev_q <= rd_data;
    end
  end

`ifdef DM_SORT_CHECKER_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (violation && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

  assign rd_en      = (state_q == READ);
  assign rd_addr    = rd_en ? (BASE_ADDR + {22'd0, idx_q, 2'b00}) : 32'd0;
  assign busy       = (state_q == READ) || (state_q == CAPTURE);
  assign done       = (state_q == DONE);
  assign pass       = done && !viol_q;
  assign fail_index = fail_idx_q;

endmodule

// File: tb/tb_dm_sort_checker.sv
// Directed bench for dm_sort_checker with a synchronous-read memory model and a negedge bus monitor.
module tb_dm_sort_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc  = 32'd0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        busy, done, pass;
  logic [7:0]  fail_index;
`ifdef DM_SORT_CHECKER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  dm_sort_checker dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_index (fail_index)
`ifdef DM_SORT_CHECKER_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  logic [31:0] mem [12];
  logic [31:0] sorted_v   [12] = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
  logic [31:0] unsorted_v [12] = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
  logic [31:0] dup_v      [12] = '{0, 11, 22, 33, 44, 55, 55, 77, 88, 99, 110, 121};

  // Data memory: one-cycle read latency; junk when idle to expose mistimed captures
  logic [31:0] off;
  assign off = rd_addr - 32'd512;
  always @(posedge clk) begin
    if (rd_en && off < 32'd48) rd_data <= mem[off[5:2]];
    else                       rd_data <= 32'hDEAD_BEEF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          rd_cnt, consec, first_rd_cyc, done_cyc;
  logic        prev_rd, done_seen;
  logic [31:0] rd_addrs [16];
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; consec = 0; first_rd_cyc = -1; done_cyc = -1;
      prev_rd = 1'b0; done_seen = 1'b0;
    end else begin
      if (rd_en) begin
        if (rd_cnt == 0) first_rd_cyc = cyc + 1;
        if (rd_cnt < 16) rd_addrs[rd_cnt] = rd_addr;
        if (prev_rd) consec++;
        rd_cnt++;
      end
      prev_rd = rd_en;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc + 1;
      end
    end
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc  = 32'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Presents HALT_PC for one edge and returns that edge number
  task automatic start_scan(output int t);
    pc = 32'd92;
    step();
    t = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && !done; k++) step();
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    step();
  endtask

  int t0;

  initial begin
    // Reset values
    do_reset();
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fail_index", {24'd0, fail_index}, 32'd0);
`ifdef DM_SORT_CHECKER_ERRCNT_EN
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    repeat (3) step();
    chk("idle_no_busy", {31'd0, busy}, 32'd0);

    // Sorted array, pc left at HALT_PC afterwards
    mem = sorted_v;
    do_reset();
    start_scan(t0);
    chk("sorted_busy_early", {31'd0, busy}, 32'd1);
    wait_done("sorted");
    chk("sorted_reads", rd_cnt, 32'd12);
    chk("sorted_consec", consec, 32'd0);
    chk("sorted_first_rd", first_rd_cyc, t0 + 1);
    for (int i = 0; i < 12; i++) chk("sorted_addr", rd_addrs[i], 32'd512 + 32'(4 * i));
    chk("sorted_done_cyc", done_cyc, t0 + 25);
    chk("sorted_pass", {31'd0, pass}, 32'd1);
    chk("sorted_fail_index", {24'd0, fail_index}, 32'd0);
    chk("sorted_busy_end", {31'd0, busy}, 32'd0);
`ifdef DM_SORT_CHECKER_ERRCNT_EN
    chk("sorted_err_count", {24'd0, err_count}, 32'd0);
`endif
    repeat (100) step();
    chk("hold_reads", rd_cnt, 32'd12);
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_pass", {31'd0, pass}, 32'd1);
    chk("hold_busy", {31'd0, busy}, 32'd0);

    // Unsorted array
    mem = unsorted_v;
    do_reset();
    start_scan(t0);
    wait_done("unsorted");
    chk("unsorted_fail_index", {24'd0, fail_index}, 32'd2);
    chk("unsorted_pass", {31'd0, pass}, 32'd0);
    chk("unsorted_consec", consec, 32'd0);
`ifdef DM_SORT_CHECKER_ERRCNT_EN
    chk("unsorted_reads", rd_cnt, 32'd12);
    chk("unsorted_done_cyc", done_cyc, t0 + 25);
    chk("unsorted_err_count", {24'd0, err_count}, 32'd5);
`else
    chk("unsorted_reads", rd_cnt, 32'd3);
    chk("unsorted_done_cyc", done_cyc, t0 + 7);
`endif

    // Equal adjacent words at indices 5 and 6
    mem = dup_v;
    do_reset();
    start_scan(t0);
    wait_done("dup");
    chk("dup_fail_index", {24'd0, fail_index}, 32'd6);
    chk("dup_pass", {31'd0, pass}, 32'd0);
`ifdef DM_SORT_CHECKER_ERRCNT_EN
    chk("dup_reads", rd_cnt, 32'd12);
    chk("dup_done_cyc", done_cyc, t0 + 25);
    chk("dup_err_count", {24'd0, err_count}, 32'd1);
`else
    chk("dup_reads", rd_cnt, 32'd7);
    chk("dup_done_cyc", done_cyc, t0 + 15);
`endif

    // Reset sampled at edge T+8 aborts the scan
    mem = sorted_v;
    do_reset();
    start_scan(t0);
    repeat (7) step();
    rst = 1'b1;
    pc  = 32'd0;
    step();
    chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
    chk("abort_rd_addr", rd_addr, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    rst = 1'b0;
    repeat (10) step();
    chk("abort_no_reads", rd_cnt, 32'd0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    start_scan(t0);
    wait_done("restart");
    chk("restart_first_addr", rd_addrs[0], 32'd512);
    chk("restart_reads", rd_cnt, 32'd12);
    chk("restart_done_cyc", done_cyc, t0 + 25);
    chk("restart_pass", {31'd0, pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
